decoder_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 3-to-8 active-low select decoder among eight requesters. It samples a request vector and picks one winner. It drives the decoder's address (A) and enable inputs (G1, GN2, GN3) so that exactly one decoder output goes low for the granted requester. It enforces a maximum hold time and a turnaround gap with all decoder outputs high between grants.

---
 rtl/decoder_arb_pkg.sv | 22 ++
 rtl/rr_pick8.sv | 34 +++
 rtl/decoder_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_decoder_rr_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_arb_pkg.sv
// Shared types and constants for the round-robin decoder arbiter.
// The enable triple is ordered {G1, GN2, GN3}.
package decoder_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [2:0] EN_ON  = 3'b100;
    localparam logic [2:0] EN_OFF = 3'b011;

    // Successor index in the circular search order; wraps 7 -> 0.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] k);
        return k + 3'd1;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching upward modulo 8.
module rr_pick8
    import decoder_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] dbl_shift;
    logic [NUM_REQ-1:0]   rot;
    logic [SEL_W-1:0]     off;

    // Doubling the vector turns the rotate into a plain shift.
    assign dbl       = {req, req};
    assign dbl_shift = dbl >> ptr;
    assign rot       = dbl_shift[NUM_REQ-1:0];

    always_comb begin
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
    end

    assign any = |req;
    assign idx = ptr + off;

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter driving a shared 3-to-8 active-low decoder, with a
// per-grant hold limit and an all-off turnaround gap between grants.
//
//   state | meaning
//   IDLE  | no grant; arbitrate every edge
//   GRANT | decoder enabled for requester A; hold_cnt counts grant cycles
//   GAP   | decoder disabled; gap_cnt counts turnaround cycles, arbitrate on the last
module decoder_rr_arbiter
    import decoder_arb_pkg::*;
#(
    parameter int MAX_HOLD   = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req,
    output logic [SEL_W-1:0]    A,
    output logic                G1,
    output logic                GN2,
    output logic                GN3,
    output logic                busy,
    output logic                timeout
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [3:0]        GAP_LAST  = 4'(GAP_CYCLES - 1);

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  ptr, ptr_nxt;
    logic [SEL_W-1:0]  a_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [3:0]        gap_cnt, gap_nxt;
    logic              timeout_nxt;
    logic              arb;
    logic              pick_any;
    logic [SEL_W-1:0]  pick_idx;
    logic [2:0]        en_nxt;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        state_nxt   = state;
        a_nxt       = A;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        gap_nxt     = gap_cnt;
        timeout_nxt = 1'b0;
        arb         = 1'b0;

        case (state)
            IDLE: begin
                arb = 1'b1;
            end
            GRANT: begin
                // A released request wins over the hold limit: no timeout then.
                if (!req[A]) begin
                    state_nxt = GAP;
                    gap_nxt   = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt   = GAP;
                    gap_nxt     = '0;
                    timeout_nxt = 1'b1;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    arb = 1'b1;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (arb) begin
            if (pick_any) begin
                state_nxt = GRANT;
                a_nxt     = pick_idx;
                ptr_nxt   = next_idx(pick_idx);
                hold_nxt  = '0;
            end else begin
                state_nxt = IDLE;
            end
        end

        en_nxt = (state_nxt == GRANT) ? EN_ON : EN_OFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ptr            <= '0;
            hold_cnt       <= '0;
            gap_cnt        <= '0;
            A              <= '0;
            {G1, GN2, GN3} <= EN_OFF;
            busy           <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            state          <= state_nxt;
            ptr            <= ptr_nxt;
            hold_cnt       <= hold_nxt;
            gap_cnt        <= gap_nxt;
            A              <= a_nxt;
            {G1, GN2, GN3} <= en_nxt;
            busy           <= (state_nxt != IDLE);
            timeout        <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Self-checking bench for decoder_rr_arbiter: directed scenarios plus random
// request traffic compared cycle by cycle against a behavioural model.
module tb_decoder_rr_arbiter;

    localparam int MH = 3;
    localparam int GC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [2:0] A;
    logic       G1, GN2, GN3, busy, timeout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decoder_rr_arbiter #(.MAX_HOLD(MH), .GAP_CYCLES(GC)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .A       (A),
        .G1      (G1),
        .GN2     (GN2),
        .GN3     (GN3),
        .busy    (busy),
        .timeout (timeout)
    );

    // Model: phase 0 = idle, 1 = granted, 2 = turnaround.
    int m_phase, m_a, m_ptr, m_held, m_gap_left, m_w;
    bit m_to, m_arb;

    function automatic int find_winner(input logic [7:0] r, input int start);
        for (int i = 0; i < 8; i++) begin
            if (r[(start + i) % 8]) return (start + i) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_a = 0; m_ptr = 0; m_held = 0; m_gap_left = 0; m_to = 0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        m_arb = 0;
        m_to  = 0;
        case (m_phase)
            0: m_arb = 1;
            1: begin
                m_held++;
                if (!req[m_a]) begin
                    m_phase = 2; m_gap_left = GC;
                end else if (m_held == MH) begin
                    m_phase = 2; m_gap_left = GC; m_to = 1;
                end
            end
            default: begin
                m_gap_left--;
                if (m_gap_left == 0) m_arb = 1;
            end
        endcase
        if (m_arb) begin
            m_w = find_winner(req, m_ptr);
            if (m_w < 0) begin
                m_phase = 0;
            end else begin
                m_phase = 1; m_a = m_w; m_ptr = (m_w + 1) % 8; m_held = 0;
            end
        end
    endtask

    function automatic logic [7:0] m_out();
        logic on;
        on = (m_phase == 1);
        return {3'(m_a), on, !on, !on, (m_phase != 0), m_to};
    endfunction

    function automatic logic [7:0] dut_out();
        return {A, G1, GN2, GN3, busy, timeout};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 8'h00;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (dut_out() !== 8'b000_0_1_1_0_0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: got %b expected %b", i, dut_out(), 8'b000_0_1_1_0_0);
            end
        end
    endtask

    task automatic test_single();
        int on_cnt = 0;
        req = 8'h04;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 1) req = 8'h00;
            if (G1 === 1'b1 && A === 3'd2) on_cnt++;
            checks++;
            if (dut_out() !== m_out()) begin
                errors++;
                $display("FAIL single_model cyc%0d: got %b expected %b", i, dut_out(), m_out());
            end
        end
        checks++;
        if (on_cnt != 2) begin
            errors++;
            $display("FAIL single_len: got %0d expected %0d", on_cnt, 2);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got busy=%b expected 0", busy);
        end
        // ptr now sits at 3, so 3 must beat 2.
        req = 8'h0C;
        tick();
        checks++;
        if ({A, G1} !== {3'd3, 1'b1}) begin
            errors++;
            $display("FAIL single_ptr: got A=%0d G1=%b expected A=3 G1=1", A, G1);
        end
        req = 8'h00;
        repeat (5) tick();
    endtask

    task automatic test_all_high();
        int order[$];
        int run = 0, to_cnt = 0;
        logic prev = 1'b0;
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 9 * (MH + GC); i++) begin
            tick();
            checks++;
            if (dut_out() !== m_out()) begin
                errors++;
                $display("FAIL all_model cyc%0d: got %b expected %b", i, dut_out(), m_out());
            end
            if (G1 && !prev) order.push_back(int'(A));
            if (G1) run++;
            if (!G1 && prev) begin
                checks++;
                if (run != MH) begin
                    errors++;
                    $display("FAIL all_runlen: got %0d expected %0d", run, MH);
                end
                run = 0;
            end
            if (timeout) to_cnt++;
            prev = G1;
        end
        checks++;
        if (order.size() != 9) begin
            errors++;
            $display("FAIL all_count: got %0d expected %0d", order.size(), 9);
        end
        for (int k = 0; k < order.size(); k++) begin
            checks++;
            if (order[k] != k % 8) begin
                errors++;
                $display("FAIL all_order[%0d]: got %0d expected %0d", k, order[k], k % 8);
            end
        end
        checks++;
        if (to_cnt != 9) begin
            errors++;
            $display("FAIL all_timeouts: got %0d expected %0d", to_cnt, 9);
        end
        req = 8'h00;
    endtask

    task automatic test_wrap();
        int order[$];
        int exp_order[3] = '{7, 0, 7};
        logic prev = 1'b0;
        do_reset();
        req = 8'h40;
        tick();
        req = 8'h00;
        repeat (4) tick();
        req = 8'h81;
        for (int i = 0; i < 3 * (MH + GC); i++) begin
            tick();
            checks++;
            if (dut_out() !== m_out()) begin
                errors++;
                $display("FAIL wrap_model cyc%0d: got %b expected %b", i, dut_out(), m_out());
            end
            if (G1 && !prev) order.push_back(int'(A));
            prev = G1;
        end
        checks++;
        if (order.size() != 3) begin
            errors++;
            $display("FAIL wrap_count: got %0d expected 3", order.size());
        end
        for (int k = 0; k < 3 && k < order.size(); k++) begin
            checks++;
            if (order[k] != exp_order[k]) begin
                errors++;
                $display("FAIL wrap_order[%0d]: got %0d expected %0d", k, order[k], exp_order[k]);
            end
        end
        req = 8'h00;
    endtask

    task automatic test_only5();
        logic [2:0] exp_v;
        do_reset();
        req = 8'h20;
        for (int i = 0; i < 2 * (MH + GC); i++) begin
            tick();
            exp_v = {((i % (MH + GC)) < MH), ((i % (MH + GC)) == MH), 1'b1};
            checks++;
            if ({G1, timeout, A == 3'd5} !== exp_v) begin
                errors++;
                $display("FAIL only5 cyc%0d: got G1=%b timeout=%b A=%0d expected G1=%b timeout=%b A=5",
                         i, G1, timeout, A, exp_v[2], exp_v[1]);
            end
        end
        req = 8'h00;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'hFF;
        tick();
        tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({A, G1, GN2, GN3, busy, timeout} !== 8'b000_0_1_1_0_0) begin
            errors++;
            $display("FAIL reset_mid_async: got %b expected %b", dut_out(), 8'b000_0_1_1_0_0);
        end
        @(negedge clk);
        rst = 1'b0;
        req = 8'h10;
        tick();
        checks++;
        if ({A, G1, GN2, GN3} !== {3'd4, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_regrant: got A=%0d en=%b%b%b expected A=4 en=100", A, G1, GN2, GN3);
        end
        req = 8'h00;
        repeat (6) tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: req = 8'h00;
                    1: req = 8'(1 << $urandom_range(0, 7));
                    2: req = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
                    default: req = 8'($urandom_range(0, 255));
                endcase
            end
            tick();
            checks++;
            if (dut_out() !== m_out()) begin
                errors++;
                $display("FAIL random cyc%0d: got %b expected %b (req=%h)", i, dut_out(), m_out(), req);
            end
        end
        req = 8'h00;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_all_high();
        test_wrap();
        test_only5();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
